// File: rtl/sequential_divider_8by4.sv
// sequential_divider_8by4: multi-cycle restoring divider, 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Ports: clk, reset (sync, active-high); ui_in = dividend; uio_in[3:0] = divisor; in_valid = start (IDLE only);
//        uo_out = quotient; uio_out = {3'b0, div_by_zero, remainder[3:0]}; uio_oe = 8'h1F during out_done;
//        out_done = one-cycle result pulse; busy = high in RUN and DONE.
// Build option: define DIV_ZERO_FASTPATH_EN to finish a divide-by-zero straight from IDLE (latency 1).
module sequential_divider_8by4 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       in_valid,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       out_done,
    output logic       busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [7:0] q;
    logic [4:0] r;
    logic [3:0] d;
    logic [3:0] lo;
    logic [2:0] cnt;
    logic [4:0] t;
    logic       ge;
    logic [4:0] r_n;
    logic [7:0] q_n;
    always_comb begin
        t   = {r[3:0], q[7]};
        ge  = t >= {1'b0, d};
        r_n = ge ? t - {1'b0, d} : t;
        q_n = {q[6:0], ge};
    end
    assign busy = state != IDLE;
    // lo keeps dividend[3:0] because Q is consumed by the shift; it is the forced divide-by-zero remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            q        <= '0;
            r        <= '0;
            d        <= '0;
            lo       <= '0;
            cnt      <= '0;
            uo_out   <= '0;
            uio_out  <= '0;
            uio_oe   <= '0;
            out_done <= 1'b0;
        end else begin
            out_done <= 1'b0;
            uio_oe   <= 8'h00;
            case (state)
                IDLE: if (in_valid) begin
                    q     <= ui_in;
                    d     <= uio_in[3:0];
                    lo    <= ui_in[3:0];
                    r     <= '0;
                    cnt   <= 3'd7;
                    state <= RUN;
`ifdef DIV_ZERO_FASTPATH_EN
                    if (uio_in[3:0] == 4'd0) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                        uio_oe   <= 8'h1F;
                        uo_out   <= 8'hFF;
                        uio_out  <= {4'b0001, ui_in[3:0]};
                    end
`endif
                end
                RUN: begin
                    r   <= r_n;
                    q   <= q_n;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                        uio_oe   <= 8'h1F;
                        uo_out   <= d == 4'd0 ? 8'hFF : q_n;
                        uio_out  <= d == 4'd0 ? {4'b0001, lo} : {4'b0000, r_n[3:0]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider_8by4.sv
// tb_sequential_divider_8by4: scoreboard bench for sequential_divider_8by4 with a plain-arithmetic reference model.
module tb_sequential_divider_8by4;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic       in_valid = 1'b0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       out_done;
    logic       busy;

    sequential_divider_8by4 dut (
        .clk(clk), .reset(reset), .ui_in(ui_in), .uio_in(uio_in), .in_valid(in_valid),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .out_done(out_done), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    typedef struct {
        logic [7:0] quo;
        logic [7:0] aux;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_q = '0;
    logic [7:0] last_o = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference: quotient/remainder by plain division; divisor 0 gives FF, flag, low dividend nibble.
    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b, input int acc);
        exp_t e;
        if (b == 4'd0) begin
            e.quo = 8'hFF;
            e.aux = {4'b0001, a[3:0]};
            e.cyc = acc + ZLAT;
        end else begin
            e.quo = 8'(a / b);
            e.aux = 8'(a % b);
            e.cyc = acc + 8;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", uo_out, e.quo);
                    chk("rem_flag", uio_out, e.aux);
                    chk("oe_done", uio_oe, 8'h1F);
                    chk("latency_cycle", cyc, e.cyc);
                    chk("busy_done", busy, 1);
                end
            end else begin
                chk("oe_idle", uio_oe, 0);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge before E1.
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        chk("hold_quotient", uo_out, last_q);
        chk("hold_rem", uio_out, last_o);
        ui_in = a;
        uio_in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b[3:0], cyc);
        sb.push_back(e);
        last_q = e.quo;
        last_o = e.aux;
        @(negedge clk);
        in_valid = 1'b0;
        ui_in = 8'($urandom);
        uio_in = 8'($urandom);
    endtask

    // Waits for the result pulse, then moves to the first IDLE cycle after DONE.
    task automatic wait_done();
        int k = 0;
        while (!out_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_done) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b);
        start(a, b);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_uo_out", uo_out, 0);
        chk("rst_uio_out", uio_out, 0);
        chk("rst_uio_oe", uio_oe, 0);
        chk("rst_out_done", out_done, 0);
        chk("rst_busy", busy, 0);

        op(8'd200, 8'd7);
        op(8'd255, 8'd15);
        op(8'd5, 8'd9);
        op(8'd0, 8'd3);
        op(8'd100, 8'd0);
        op(8'd100, 8'hF0);

        // Request during RUN must be ignored.
        start(8'd200, 8'd7);
        @(negedge clk);
        chk("busy_run", busy, 1);
        @(negedge clk);
        ui_in = 8'd50;
        uio_in = 8'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        chk("idle_after_done", busy, 0);

        // Reset at E4 aborts the operation.
        start(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        last_q = '0;
        last_o = '0;
        chk("abort_uo_out", uo_out, 0);
        chk("abort_uio_out", uio_out, 0);
        chk("abort_busy", busy, 0);
        repeat (12) @(negedge clk);
        op(8'd9, 8'd2);

        // Reset wins over a simultaneous request.
        reset = 1'b1;
        in_valid = 1'b1;
        ui_in = 8'd9;
        uio_in = 8'd2;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst_wins_busy", busy, 0);
        last_q = '0;
        last_o = '0;
        repeat (3) @(negedge clk);
        chk("rst_wins_idle", busy, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i % 7 == 0) b[3:0] = 4'd0;
            op(8'($urandom), b);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
